// File: rtl/eaglesong_pkg.sv
// Shared Eaglesong constants and the bit-matrix step FSM encoding.
// Imported by the step top, its column mixer and the handshake interface.
package eaglesong_pkg;

    localparam int EAGLESONG_NUM_WORDS = 16;
    localparam int EAGLESONG_WORD_W = 32;

    localparam logic [255:0] EAGLESONG_BIT_MATRIX =
        256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } bm_state_t;

endpackage

// File: rtl/eaglesong_bit_matrix_step_if.sv
// Valid/ready bundle for one Eaglesong state in and one mixed state out.
// The block is the slave side; the round logic driving it is the master.
interface eaglesong_bit_matrix_step_if
    import eaglesong_pkg::*;
#(
    parameter int WORD_W = EAGLESONG_WORD_W
);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [EAGLESONG_NUM_WORDS*WORD_W-1:0] in_state;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [EAGLESONG_NUM_WORDS*WORD_W-1:0] out_state;
    logic                                  busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/eaglesong_bm_column.sv
// One output word of the GF(2) bit-matrix mix: XOR of the input
// words selected by a 16-bit matrix column.
module eaglesong_bm_column
    import eaglesong_pkg::*;
#(
    parameter int WORD_W = EAGLESONG_WORD_W
) (
    input  logic [EAGLESONG_NUM_WORDS*WORD_W-1:0] words,
    input  logic [EAGLESONG_NUM_WORDS-1:0]        column,
    output logic [WORD_W-1:0]                     word
);

    always_comb begin
        word = '0;
        for (int k = 0; k < EAGLESONG_NUM_WORDS; k++) begin
            if (column[k]) word = word ^ words[k*WORD_W +: WORD_W];
        end
    end

endmodule

// File: rtl/eaglesong_bit_matrix_step.sv
// Iterative Eaglesong bit-matrix step, OUTS_PER_CYCLE words per cycle.
// Optional EAGLESONG_BM_LOADABLE_EN adds a writable matrix register.
module eaglesong_bit_matrix_step
    import eaglesong_pkg::*;
#(
    parameter int           WORD_W         = EAGLESONG_WORD_W,
    parameter int           OUTS_PER_CYCLE = 4,
    parameter logic [255:0] MATRIX         = EAGLESONG_BIT_MATRIX
) (
    input  logic clk,
    input  logic reset,
`ifdef EAGLESONG_BM_LOADABLE_EN
    input  logic         mat_wr_en,
    input  logic [255:0] mat_wr_data,
`endif
    eaglesong_bit_matrix_step_if.slave bus
);

    localparam int N      = EAGLESONG_NUM_WORDS;
    localparam int P      = OUTS_PER_CYCLE;
    localparam int GROUPS = N / P;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

    if (P != 1 && P != 2 && P != 4 && P != 8 && P != 16) begin : g_bad_p
        $error("OUTS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    bm_state_t           state;
    bm_state_t           state_next;
    logic                accept;
    logic [CW-1:0]       cnt;
    logic [N*WORD_W-1:0] latch;
    logic [WORD_W-1:0]   out_q [N];
    logic [255:0]        mat;
    logic [3:0]          col_idx [P];
    logic [WORD_W-1:0]   col_word [P];

`ifdef EAGLESONG_BM_LOADABLE_EN
    // A write racing an accepted state is dropped so a pass never mixes matrices.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mat <= MATRIX;
        end else if (state == IDLE && mat_wr_en && !bus.in_valid) begin
            mat <= mat_wr_data;
        end
    end
`else
    assign mat = MATRIX;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        accept        = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept) state_next = COMPUTE;
            end
            COMPUTE: begin
                bus.busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            latch <= '0;
            for (int j = 0; j < N; j++) out_q[j] <= '0;
        end else if (accept) begin
            cnt   <= '0;
            latch <= bus.in_state;
        end else if (state == COMPUTE) begin
            if (cnt != LAST) cnt <= cnt + CW'(1);
            for (int l = 0; l < P; l++) begin
                out_q[col_idx[l]] <= col_word[l];
            end
        end
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        logic [N-1:0] column;

        assign col_idx[l] = 4'(int'(cnt) * P + l);

        always_comb begin
            column = '0;
            for (int k = 0; k < N; k++) begin
                column[k] = mat[k*N + int'(col_idx[l])];
            end
        end

        eaglesong_bm_column #(
            .WORD_W (WORD_W)
        ) u_col (
            .words  (latch),
            .column (column),
            .word   (col_word[l])
        );
    end

    always_comb begin
        bus.out_state = '0;
        for (int j = 0; j < N; j++) begin
            bus.out_state[j*WORD_W +: WORD_W] = out_q[j];
        end
    end

endmodule

// File: tb/tb_eaglesong_bit_matrix_step.sv
// Bench for eaglesong_bit_matrix_step: directed vectors, a P sweep and
// a random handshake run checked against a plain GF(2) matrix model.
`timescale 1ns/1ps
module tb_eaglesong_bit_matrix_step;
    import eaglesong_pkg::*;

    localparam int W = 32;
    localparam int PS [5] = '{1, 2, 4, 8, 16};
    typedef logic [16*W-1:0] st_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int npop = 0;
    logic [255:0] cur_mat = EAGLESONG_BIT_MATRIX;
    st_t exp_q [$];

    eaglesong_bit_matrix_step_if #(.WORD_W(W)) bus ();

`ifdef EAGLESONG_BM_LOADABLE_EN
    logic         mat_wr_en = 1'b0;
    logic [255:0] mat_wr_data = '0;
`endif

    eaglesong_bit_matrix_step #(
        .WORD_W         (W),
        .OUTS_PER_CYCLE (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef EAGLESONG_BM_LOADABLE_EN
        .mat_wr_en   (mat_wr_en),
        .mat_wr_data (mat_wr_data),
`endif
        .bus         (bus)
    );

    logic       sw_valid = 1'b0;
    st_t        sw_state = '0;
    logic [4:0] sw_ov;
    logic [4:0] sw_ir;
    logic [4:0] sw_busy;
    st_t        sw_os [5];

    for (genvar g = 0; g < 5; g++) begin : g_sw
        eaglesong_bit_matrix_step_if #(.WORD_W(W)) sb ();
        assign sb.in_valid  = sw_valid;
        assign sb.in_state  = sw_state;
        assign sb.out_ready = 1'b1;
        assign sw_ov[g]     = sb.out_valid;
        assign sw_ir[g]     = sb.in_ready;
        assign sw_busy[g]   = sb.busy;
        assign sw_os[g]     = sb.out_state;

        eaglesong_bit_matrix_step #(
            .WORD_W         (W),
            .OUTS_PER_CYCLE (PS[g])
        ) u_sw (
            .clk         (clk),
            .reset       (reset),
`ifdef EAGLESONG_BM_LOADABLE_EN
            .mat_wr_en   (1'b0),
            .mat_wr_data (256'd0),
`endif
            .bus         (sb)
        );
    end

    // new[j] = XOR over k of (M[k*16+j] ? s[k] : 0)
    function automatic st_t model(input st_t s, input logic [255:0] m);
        st_t r;
        r = '0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 16; k++)
                if (m[k*16+j]) r[j*W +: W] ^= s[k*W +: W];
        return r;
    endfunction

    function automatic st_t rnd();
        st_t r;
        for (int i = 0; i < 16; i++) r[i*W +: W] = $urandom();
        return r;
    endfunction

    function automatic st_t from_mask(input logic [15:0] m);
        st_t r;
        r = '0;
        for (int j = 0; j < 16; j++) r[j*W] = m[j];
        return r;
    endfunction

    task automatic chk(input string nm, input st_t act, input st_t req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic chki(input string nm, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic send(input st_t s);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        bus.in_state = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        chki("send_accept", int'(ok), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) break;
        end
    endtask

    task automatic release_out();
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chki({tag, "_in_ready"}, int'(bus.in_ready), 1);
        chki({tag, "_out_valid"}, int'(bus.out_valid), 0);
        chki({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_out_state"}, bus.out_state, '0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.in_state, cur_mat));
            chki("ready_vs_busy", int'(bus.in_ready), int'(!bus.busy));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chki("spurious_out_valid", 1, 0);
                end else begin
                    chk("cmp_out_state", bus.out_state, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        npop++;
                    end
                end
            end
        end
    end

    initial begin
        st_t s;
        st_t e;
        st_t ones;
        int  lat;
        int  sw_lat [5];
        int  sent;
        int  pop0;
        bit  took;
`ifdef EAGLESONG_BM_LOADABLE_EN
        logic [255:0] ident;
`endif

        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b0;

        #12;
        chk_reset_vals("rst");
        @(posedge clk); #1 reset = 1'b0;

        // Unit vectors pin the model to the literal matrix rows.
        s = '0;
        s[0] = 1'b1;
        e = from_mask(16'h8faf);
        chk("model_unit0", model(s, EAGLESONG_BIT_MATRIX), e);
        s = '0;
        s[15*W] = 1'b1;
        chk("model_unit15", model(s, EAGLESONG_BIT_MATRIX),
            from_mask(16'h47d7));

        s = '0;
        s[0] = 1'b1;
        send(s);
        wait_out(lat);
        chki("unit_lat", lat, 5);
        chk("unit_data", bus.out_state, e);
        release_out();

        // All-ones: every column has odd parity except column 15.
        ones = '1;
        e = '0;
        for (int j = 0; j < 15; j++) e[j*W +: W] = '1;
        chk("model_ones", model(ones, EAGLESONG_BIT_MATRIX), e);
        @(posedge clk); #1;
        sw_state = ones;
        sw_valid = 1'b1;
        @(negedge clk);
        chki("sw_in_ready", int'(sw_ir), 31);
        @(posedge clk); #1 sw_valid = 1'b0;
        for (int g = 0; g < 5; g++) sw_lat[g] = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) chki("sw_busy", int'(sw_busy), 31);
            for (int g = 0; g < 5; g++) begin
                if (sw_ov[g] && sw_lat[g] == 0) begin
                    sw_lat[g] = c;
                    chk($sformatf("sw_data_p%0d", PS[g]), sw_os[g], e);
                end
            end
        end
        for (int g = 0; g < 5; g++)
            chki($sformatf("sw_lat_p%0d", PS[g]), sw_lat[g], 16 / PS[g] + 1);

        // Backpressure with an ignored second request.
        s = rnd();
        e = model(s, EAGLESONG_BIT_MATRIX);
        send(s);
        wait_out(lat);
        chki("bp_lat", lat, 5);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                bus.in_state = rnd();
                bus.in_valid = 1'b1;
            end
            if (c == 6) bus.in_valid = 1'b0;
            @(negedge clk);
            chki("bp_valid", int'(bus.out_valid), 1);
            chki("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_data", bus.out_state, e);
        end
        release_out();
        @(negedge clk);
        chki("bp_drop", int'(bus.out_valid), 0);
        chki("bp_idle", int'(bus.in_ready), 1);
        chk("bp_hold", bus.out_state, e);

        // Async reset two cycles into COMPUTE.
        send(rnd());
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1 reset = 1'b0;
        s = rnd();
        send(s);
        wait_out(lat);
        chki("post_rst_lat", lat, 5);
        chk("post_rst_data", bus.out_state, model(s, EAGLESONG_BIT_MATRIX));
        release_out();

`ifdef EAGLESONG_BM_LOADABLE_EN
        ident = '0;
        for (int k = 0; k < 16; k++) ident[k*16+k] = 1'b1;
        @(posedge clk); #1;
        mat_wr_en   = 1'b1;
        mat_wr_data = ident;
        @(posedge clk); #1;
        mat_wr_en = 1'b0;
        cur_mat   = ident;
        s = rnd();
        send(s);
        @(posedge clk); #1;
        mat_wr_en   = 1'b1;
        mat_wr_data = '0;
        @(posedge clk); #1 mat_wr_en = 1'b0;
        wait_out(lat);
        chk("ident_data", bus.out_state, s);
        release_out();
        s = rnd();
        send(s);
        wait_out(lat);
        chk("ident_keep", bus.out_state, s);
        release_out();
        @(posedge clk); #1;
        mat_wr_en   = 1'b1;
        mat_wr_data = EAGLESONG_BIT_MATRIX;
        @(posedge clk); #1;
        mat_wr_en = 1'b0;
        cur_mat   = EAGLESONG_BIT_MATRIX;
`endif

        // Random back-to-back traffic, compare process checks each result.
        pop0 = npop;
        sent = 0;
        took = 1'b0;
        for (int cyc = 0; cyc < 30000 && sent < 1000; cyc++) begin
            @(posedge clk); #1;
            if (took) begin
                bus.in_valid = 1'b0;
                bus.in_state = rnd();
            end
            if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                bus.in_state = rnd();
                bus.in_valid = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) sent++;
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chki("rand_sent", sent, 1000);
        chki("rand_count", npop - pop0, 1000);
        chki("rand_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
